// File: rtl/ks_sum_normalize_pkg.sv
// Shared constants for the Kogge-Stone sum/normalize back end.
package ks_sum_normalize_pkg;

    localparam int KS_W    = 25;          // adder width (G/P0 width)
    localparam int KS_LZW  = 5;           // leading-zero count width
    localparam int ZERO_LZ = KS_W + 1;    // count reported for an all-zero sum

endpackage

// File: rtl/ks_lzc.sv
// Combinational leading-zero counter over N bits; count = N and zero = 1 for all-zero input.
import ks_sum_normalize_pkg::*;

module ks_lzc #(
    parameter int N  = ZERO_LZ,
    parameter int CW = KS_LZW
) (
    input  logic [N-1:0]  i_data,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    // Scan from MSB; the first set bit found fixes the count.
    always_comb begin
        o_count = CW'(N);
        o_zero  = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_data[i] && o_zero) begin
                o_count = CW'(N - 1 - i);
                o_zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ks_sum_normalize.sv
// Kogge-Stone adder back end: sum formation, leading-zero count, left normalize.
// Three registered stages, valid/ready handshake with a single global stall.
// Optional carry-in (ports in_cin, in_P) enabled by defining KS_CIN_EN.
import ks_sum_normalize_pkg::*;

module ks_sum_normalize #(
    parameter int W   = KS_W,
    parameter int LZW = KS_LZW
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_G,
    input  logic [W-1:0]   in_P0,
    input  logic           in_sign,
`ifdef KS_CIN_EN
    input  logic           in_cin,
    input  logic [W-1:0]   in_P,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W:0]     out_mant,
    output logic [LZW-1:0] out_shift,
    output logic           out_zero,
    output logic           out_sign
);

    logic           w_adv;
    logic [W:0]     w_carry;
    logic [W:0]     w_sum;
    logic [LZW-1:0] w_lz;
    logic           w_zero;

    logic           r_s1_valid;
    logic [W:0]     r_s1_sum;
    logic           r_s1_sign;

    logic           r_s2_valid;
    logic [W:0]     r_s2_sum;
    logic [LZW-1:0] r_s2_lz;
    logic           r_s2_zero;
    logic           r_s2_sign;

    logic           r_s3_valid;
    logic [W:0]     r_s3_mant;
    logic [LZW-1:0] r_s3_lz;
    logic           r_s3_zero;
    logic           r_s3_sign;

    // The whole pipe advances together unless a result is waiting on downstream.
    assign w_adv    = !r_s3_valid || out_ready;
    assign in_ready = w_adv;

    // Carry into each bit from the resolved prefix generates (and carry-in when enabled).
    always_comb begin
`ifdef KS_CIN_EN
        w_carry[0] = in_cin;
        for (int i = 1; i <= W; i++)
            w_carry[i] = in_G[i-1] | (in_P[i-1] & in_cin);
`else
        w_carry[0] = 1'b0;
        for (int i = 1; i <= W; i++)
            w_carry[i] = in_G[i-1];
`endif
        w_sum = {w_carry[W], in_P0 ^ w_carry[W-1:0]};
    end

    // Stage 1: register the sum; data only moves when a real input is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_sign  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum  <= w_sum;
                r_s1_sign <= in_sign;
            end
        end
    end

    ks_lzc #(
        .N  (W + 1),
        .CW (LZW)
    ) u_lzc (
        .i_data  (r_s1_sum),
        .o_count (w_lz),
        .o_zero  (w_zero)
    );

    // Stage 2: register sum with its leading-zero count and zero flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_lz    <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_sign  <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sum  <= r_s1_sum;
                r_s2_lz   <= w_lz;
                r_s2_zero <= w_zero;
                r_s2_sign <= r_s1_sign;
            end
        end
    end

    // Stage 3: left-normalize into the output registers; bubbles leave data untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s3_valid <= 1'b0;
            r_s3_mant  <= '0;
            r_s3_lz    <= '0;
            r_s3_zero  <= 1'b0;
            r_s3_sign  <= 1'b0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_mant <= r_s2_zero ? '0 : (r_s2_sum << r_s2_lz);
                r_s3_lz   <= r_s2_lz;
                r_s3_zero <= r_s2_zero;
                r_s3_sign <= r_s2_sign;
            end
        end
    end

    assign out_valid = r_s3_valid;
    assign out_mant  = r_s3_mant;
    assign out_shift = r_s3_lz;
    assign out_zero  = r_s3_zero;
    assign out_sign  = r_s3_sign;

endmodule
